// File: rtl/ex_stage.sv
// Execute stage: ALU, HI/LO moves, single-cycle multiply, iterative restoring divide.
// Latency: all ops combinational except DIV/DIVU (34 cycles, 3 cycles when divisor is 0).
// Backpressure: stall_request holds id_* upstream and blocks result consumption while dividing.
//
// Ports:
//   clock, reset            - rising-edge clock, synchronous active-high reset
//   id_alu_op               - 8-bit operation code from decode
//   id_operand1/2           - source operands (rs, rt)
//   id_write_enable/addr    - GPR destination from decode
//   hilo_hi/lo_data         - committed HI/LO values
//   mem_write_hilo_enable,
//   mem_write_hi/lo_data    - HI/LO forwarding from MEM
//   ex_write_enable/addr/data           - GPR result to EX/MEM
//   ex_write_hilo_enable, ex_write_hi/lo_data - HI/LO result to EX/MEM
//   stall_request           - divider busy, pipeline must hold
module ex_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  id_alu_op,
  input  logic [31:0] id_operand1,
  input  logic [31:0] id_operand2,
  input  logic        id_write_enable,
  input  logic [4:0]  id_write_addr,
  input  logic [31:0] hilo_hi_data,
  input  logic [31:0] hilo_lo_data,
  input  logic        mem_write_hilo_enable,
  input  logic [31:0] mem_write_hi_data,
  input  logic [31:0] mem_write_lo_data,
  output logic        ex_write_enable,
  output logic [4:0]  ex_write_addr,
  output logic [31:0] ex_write_data,
  output logic        ex_write_hilo_enable,
  output logic [31:0] ex_write_hi_data,
  output logic [31:0] ex_write_lo_data,
  output logic        stall_request
);

  localparam logic [7:0] OP_NOP   = 8'b0000_0000;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
  localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

  typedef enum logic [1:0] {IDLE, BUSY, ZERO, DONE} div_state_t;

  div_state_t  div_state, div_state_next;
  logic [5:0]  div_cnt;
  logic [31:0] div_dividend;   // shifts left, feeding its MSB into the partial remainder
  logic [31:0] div_divisor;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        div_neg_quo;
  logic        div_neg_rem;

  logic        div_load, div_step, div_stall, div_result_vld;
  logic        is_div, op_signed;
  logic [31:0] mag1, mag2;
  logic [32:0] div_shifted;
  logic        div_fits;
  logic [31:0] div_rem_next;
  logic [31:0] div_hi, div_lo;

  logic [31:0] eff_hi, eff_lo;
  logic [63:0] prod_s, prod_u;

  assign eff_hi = mem_write_hilo_enable ? mem_write_hi_data : hilo_hi_data;
  assign eff_lo = mem_write_hilo_enable ? mem_write_lo_data : hilo_lo_data;

  assign prod_s = $signed(id_operand1) * $signed(id_operand2);
  assign prod_u = {32'd0, id_operand1} * {32'd0, id_operand2};

  assign is_div    = (id_alu_op == OP_DIV) || (id_alu_op == OP_DIVU);
  assign op_signed = (id_alu_op == OP_DIV);
  assign mag1 = (op_signed && id_operand1[31]) ? (32'd0 - id_operand1) : id_operand1;
  assign mag2 = (op_signed && id_operand2[31]) ? (32'd0 - id_operand2) : id_operand2;

  // Restoring step: the partial remainder is always below the divisor, so the
  // difference (when it fits) is correct in the low 32 bits.
  assign div_shifted  = {div_remainder, div_dividend[31]};
  assign div_fits     = (div_shifted >= {1'b0, div_divisor});
  assign div_rem_next = div_fits ? (div_shifted[31:0] - div_divisor) : div_shifted[31:0];

  // Signed fixup: quotient negated on differing signs, remainder follows dividend.
  assign div_lo = div_neg_quo ? (32'd0 - div_quotient)  : div_quotient;
  assign div_hi = div_neg_rem ? (32'd0 - div_remainder) : div_remainder;

  always_comb begin
    div_state_next = div_state;
    div_load       = 1'b0;
    div_step       = 1'b0;
    div_stall      = 1'b0;
    div_result_vld = 1'b0;
    case (div_state)
      IDLE: begin
        if (is_div) begin
          div_stall      = 1'b1;
          div_load       = 1'b1;
          div_state_next = (id_operand2 == 32'd0) ? ZERO : BUSY;
        end
      end
      BUSY: begin
        if (is_div) begin
          div_stall = 1'b1;
          div_step  = 1'b1;
          if (div_cnt == 6'd31) div_state_next = DONE;
        end else begin
          div_state_next = IDLE;  // op withdrawn: abandon the divide
        end
      end
      ZERO: begin
        if (is_div) begin
          div_stall      = 1'b1;
          div_state_next = DONE;
        end else begin
          div_state_next = IDLE;
        end
      end
      DONE: begin
        div_result_vld = is_div;
        div_state_next = IDLE;
      end
      default: div_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_state     <= IDLE;
      div_cnt       <= 6'd0;
      div_dividend  <= 32'd0;
      div_divisor   <= 32'd0;
      div_quotient  <= 32'd0;
      div_remainder <= 32'd0;
      div_neg_quo   <= 1'b0;
      div_neg_rem   <= 1'b0;
    end else begin
      div_state <= div_state_next;
      if (div_load) begin
        div_cnt       <= 6'd0;
        div_dividend  <= mag1;
        div_divisor   <= mag2;
        div_quotient  <= 32'd0;
        div_remainder <= 32'd0;
        div_neg_quo   <= op_signed && (id_operand1[31] ^ id_operand2[31]);
        div_neg_rem   <= op_signed && id_operand1[31];
      end else if (div_step) begin
        div_cnt       <= div_cnt + 6'd1;
        div_dividend  <= {div_dividend[30:0], 1'b0};
        div_remainder <= div_rem_next;
        div_quotient  <= {div_quotient[30:0], div_fits};
      end
    end
  end

  always_comb begin
    ex_write_enable      = 1'b0;
    ex_write_addr        = 5'd0;
    ex_write_data        = 32'd0;
    ex_write_hilo_enable = 1'b0;
    ex_write_hi_data     = 32'd0;
    ex_write_lo_data     = 32'd0;
    stall_request        = div_stall;
    case (id_alu_op)
      OP_OR, OP_AND, OP_ADDU, OP_SUBU, OP_MFHI, OP_MFLO: begin
        ex_write_enable = id_write_enable;
        ex_write_addr   = id_write_addr;
        case (id_alu_op)
          OP_OR:   ex_write_data = id_operand1 | id_operand2;
          OP_AND:  ex_write_data = id_operand1 & id_operand2;
          OP_ADDU: ex_write_data = id_operand1 + id_operand2;
          OP_SUBU: ex_write_data = id_operand1 - id_operand2;
          OP_MFHI: ex_write_data = eff_hi;
          default: ex_write_data = eff_lo;
        endcase
      end
      OP_MTHI: begin
        ex_write_hilo_enable = 1'b1;
        ex_write_hi_data     = id_operand1;
        ex_write_lo_data     = eff_lo;
      end
      OP_MTLO: begin
        ex_write_hilo_enable = 1'b1;
        ex_write_hi_data     = eff_hi;
        ex_write_lo_data     = id_operand1;
      end
      OP_MULT: begin
        ex_write_hilo_enable = 1'b1;
        {ex_write_hi_data, ex_write_lo_data} = prod_s;
      end
      OP_MULTU: begin
        ex_write_hilo_enable = 1'b1;
        {ex_write_hi_data, ex_write_lo_data} = prod_u;
      end
      OP_DIV, OP_DIVU: begin
        if (div_result_vld) begin
          ex_write_hilo_enable = 1'b1;
          ex_write_hi_data     = div_hi;
          ex_write_lo_data     = div_lo;
        end
      end
      OP_NOP: ;
      default: ;
    endcase
    if (reset) begin
      ex_write_enable      = 1'b0;
      ex_write_addr        = 5'd0;
      ex_write_data        = 32'd0;
      ex_write_hilo_enable = 1'b0;
      ex_write_hi_data     = 32'd0;
      ex_write_lo_data     = 32'd0;
      stall_request        = 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  localparam logic [7:0] OP_NOP   = 8'b0000_0000;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
  localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  id_alu_op;
  logic [31:0] id_operand1, id_operand2;
  logic        id_write_enable;
  logic [4:0]  id_write_addr;
  logic [31:0] hilo_hi_data, hilo_lo_data;
  logic        mem_write_hilo_enable;
  logic [31:0] mem_write_hi_data, mem_write_lo_data;
  logic        ex_write_enable;
  logic [4:0]  ex_write_addr;
  logic [31:0] ex_write_data;
  logic        ex_write_hilo_enable;
  logic [31:0] ex_write_hi_data, ex_write_lo_data;
  logic        stall_request;

  int n_cmp = 0;
  int n_err = 0;

  ex_stage dut (
    .clock(clock), .reset(reset),
    .id_alu_op(id_alu_op), .id_operand1(id_operand1), .id_operand2(id_operand2),
    .id_write_enable(id_write_enable), .id_write_addr(id_write_addr),
    .hilo_hi_data(hilo_hi_data), .hilo_lo_data(hilo_lo_data),
    .mem_write_hilo_enable(mem_write_hilo_enable),
    .mem_write_hi_data(mem_write_hi_data), .mem_write_lo_data(mem_write_lo_data),
    .ex_write_enable(ex_write_enable), .ex_write_addr(ex_write_addr),
    .ex_write_data(ex_write_data), .ex_write_hilo_enable(ex_write_hilo_enable),
    .ex_write_hi_data(ex_write_hi_data), .ex_write_lo_data(ex_write_lo_data),
    .stall_request(stall_request)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a, b;
    logic        we;
    logic [4:0]  addr;
    logic        mem_en;
    logic [31:0] mem_hi, mem_lo, hi_in, lo_in;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_hen;
    logic [31:0] e_hi, e_lo;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic e_we, input logic [4:0] e_addr,
                           input logic [31:0] e_data, input logic e_hen,
                           input logic [31:0] e_hi, input logic [31:0] e_lo, input logic e_stall);
    check({tag, ".we"},    64'(ex_write_enable),      64'(e_we));
    check({tag, ".addr"},  64'(ex_write_addr),        64'(e_addr));
    check({tag, ".data"},  64'(ex_write_data),        64'(e_data));
    check({tag, ".hen"},   64'(ex_write_hilo_enable), 64'(e_hen));
    check({tag, ".hi"},    64'(ex_write_hi_data),     64'(e_hi));
    check({tag, ".lo"},    64'(ex_write_lo_data),     64'(e_lo));
    check({tag, ".stall"}, 64'(stall_request),        64'(e_stall));
  endtask

  // Presents a divide at posedge+1, counts stalled cycles, then checks the DONE cycle.
  task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stalls,
                         input logic [31:0] e_hi, input logic [31:0] e_lo);
    int n;
    id_alu_op = op; id_operand1 = a; id_operand2 = b;
    n = 0;
    #4;
    while (stall_request === 1'b1 && n < 100) begin
      n++;
      @(posedge clock);
      #5;
    end
    check({tag, ".stalls"}, 64'(n), 64'(exp_stalls));
    check_all({tag, ".done"}, 1'b0, 5'd0, 32'd0, 1'b1, e_hi, e_lo, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{OP_NOP,  32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 5'd9, 1'b1, 32'h1, 32'h2, 32'h3, 32'h4,
                 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[1]  = '{OP_ADDU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 5'd5, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
                 1'b1, 5'd5, 32'h0000_0001, 1'b0, 32'h0, 32'h0};
    vecs[2]  = '{OP_OR,   32'hF0F0_0000, 32'h0000_0F0F, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
                 1'b1, 5'd3, 32'hF0F0_0F0F, 1'b0, 32'h0, 32'h0};
    vecs[3]  = '{OP_AND,  32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 5'd7, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
                 1'b1, 5'd7, 32'h0F00_0F00, 1'b0, 32'h0, 32'h0};
    vecs[4]  = '{OP_SUBU, 32'h0000_0000, 32'h0000_0001, 1'b1, 5'd31, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
                 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0};
    vecs[5]  = '{OP_ADDU, 32'h0000_0005, 32'h0000_0006, 1'b0, 5'd2, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
                 1'b0, 5'd2, 32'h0000_000B, 1'b0, 32'h0, 32'h0};
    vecs[6]  = '{OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[7]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[8]  = '{OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b1, 32'h4000_0000, 32'h0000_0000};
    vecs[9]  = '{OP_MFHI, 32'h0, 32'h0, 1'b1, 5'd4, 1'b1, 32'hABCD_0000, 32'h5555, 32'h0000_0001, 32'h2,
                 1'b1, 5'd4, 32'hABCD_0000, 1'b0, 32'h0, 32'h0};
    vecs[10] = '{OP_MFLO, 32'h0, 32'h0, 1'b1, 5'd6, 1'b0, 32'hAAAA, 32'hDEAD, 32'h1, 32'h1234_5678,
                 1'b1, 5'd6, 32'h1234_5678, 1'b0, 32'h0, 32'h0};
    vecs[11] = '{OP_MTHI, 32'hCAFE_BABE, 32'h0, 1'b1, 5'd8, 1'b1, 32'h11, 32'h55, 32'h66, 32'h77,
                 1'b0, 5'd0, 32'h0, 1'b1, 32'hCAFE_BABE, 32'h0000_0055};
    vecs[12] = '{OP_MTLO, 32'h1111_2222, 32'h0, 1'b0, 5'd0, 1'b0, 32'h11, 32'h55, 32'h77, 32'h88,
                 1'b0, 5'd0, 32'h0, 1'b1, 32'h0000_0077, 32'h1111_2222};
    vecs[13] = '{8'hFF,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd12, 1'b1, 32'h1, 32'h2, 32'h3, 32'h4,
                 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0};

    // Reset with an ALU op and a divide presented: outputs must stay quiet.
    reset = 1'b1;
    id_alu_op = OP_ADDU; id_operand1 = 32'h1; id_operand2 = 32'h2;
    id_write_enable = 1'b1; id_write_addr = 5'd1;
    hilo_hi_data = 32'h0; hilo_lo_data = 32'h0;
    mem_write_hilo_enable = 1'b0; mem_write_hi_data = 32'h0; mem_write_lo_data = 32'h0;
    tick(); tick();
    #4;
    check_all("rst.addu", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clock); #1;
    id_alu_op = OP_DIVU; id_operand1 = 32'd10; id_operand2 = 32'd2;
    #4;
    check("rst.div.stall", 64'(stall_request), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    id_alu_op = OP_NOP;
    tick();

    for (int i = 0; i < 14; i++) begin
      id_alu_op = vecs[i].op; id_operand1 = vecs[i].a; id_operand2 = vecs[i].b;
      id_write_enable = vecs[i].we; id_write_addr = vecs[i].addr;
      mem_write_hilo_enable = vecs[i].mem_en;
      mem_write_hi_data = vecs[i].mem_hi; mem_write_lo_data = vecs[i].mem_lo;
      hilo_hi_data = vecs[i].hi_in; hilo_lo_data = vecs[i].lo_in;
      #4;
      check_all($sformatf("v%0d", i), vecs[i].e_we, vecs[i].e_addr, vecs[i].e_data,
                vecs[i].e_hen, vecs[i].e_hi, vecs[i].e_lo, 1'b0);
      @(posedge clock); #1;
    end

    id_write_enable = 1'b0; id_write_addr = 5'd0; mem_write_hilo_enable = 1'b0;
    id_alu_op = OP_NOP;
    tick();

    // Divider cases; each ends in DONE and is followed by a NOP cycle.
    run_div("divu100_7",  OP_DIVU, 32'd100,       32'd7,         33, 32'd2,         32'd14);
    tick(); id_alu_op = OP_NOP; tick();
    run_div("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    tick(); id_alu_op = OP_NOP; tick();
    run_div("div_7_m2",   OP_DIV,  32'd7,         32'hFFFF_FFFE, 33, 32'd1,         32'hFFFF_FFFD);
    tick(); id_alu_op = OP_NOP; tick();
    run_div("div_min_m1", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0,         32'h8000_0000);
    tick(); id_alu_op = OP_NOP; tick();
    run_div("divu_max16", OP_DIVU, 32'hFFFF_FFFF, 32'd16,        33, 32'hF,         32'h0FFF_FFFF);
    tick(); id_alu_op = OP_NOP; tick();
    run_div("divu5_0",    OP_DIVU, 32'd5,         32'd0,         2,  32'd0,         32'd0);
    tick(); id_alu_op = OP_NOP; tick();

    // Divide held past DONE restarts from IDLE; an ALU op then cancels it.
    run_div("hold",       OP_DIVU, 32'd100,       32'd7,         33, 32'd2,         32'd14);
    tick();
    #4;
    check("hold.restart.stall", 64'(stall_request), 64'd1);
    @(posedge clock); #1;
    id_alu_op = OP_ADDU; id_operand1 = 32'd1; id_operand2 = 32'd2;
    id_write_enable = 1'b1; id_write_addr = 5'd10;
    #4;
    check_all("cancel", 1'b1, 5'd10, 32'd3, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clock); #1;
    id_write_enable = 1'b0; id_write_addr = 5'd0;
    run_div("after_cancel", OP_DIVU, 32'd5, 32'd0, 2, 32'd0, 32'd0);
    tick(); id_alu_op = OP_NOP; tick();

    // Reset during BUSY iteration 10, then a fresh divide right after release.
    id_alu_op = OP_DIVU; id_operand1 = 32'd1000; id_operand2 = 32'd3;
    for (int k = 0; k < 11; k++) tick();
    reset = 1'b1;
    #4;
    check_all("midrst", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    run_div("divu9_3", OP_DIVU, 32'd9, 32'd3, 33, 32'd0, 32'd3);
    tick(); id_alu_op = OP_NOP; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
